incubator_plant: RTL and testbench

//  Behavioural thermal model of the incubator chamber: the opposite end of the

---
 rtl/incubator_pkg.sv | 35 +++
 rtl/incubator_plant_tick_gen.sv | 32 +++
 rtl/incubator_plant.sv | 119 +++++++++++
 tb/tb_incubator_plant.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/incubator_pkg.sv
// Shared types and constants for the incubator chamber thermal model.
package incubator_pkg;

    localparam int TEMP_W  = 8;
    localparam int DELTA_W = 10;

    typedef logic signed [TEMP_W-1:0]  temp_t;
    typedef logic signed [DELTA_W-1:0] delta_t;

    localparam int T_MIN = -40;
    localparam int T_MAX = 80;

    // Cooler rotation speed codes driven by the controller.
    localparam logic [3:0] CRS_OFF  = 4'd0;
    localparam logic [3:0] CRS_LOW  = 4'd4;
    localparam logic [3:0] CRS_MED  = 4'd6;
    localparam logic [3:0] CRS_HIGH = 4'd8;

    // Heater element state: heat only reaches the chamber once HOT.
    typedef enum logic [1:0] {
        HS_COLD    = 2'd0,
        HS_WARMING = 2'd1,
        HS_HOT     = 2'd2
    } heat_state_e;

    // Saturate a wide intermediate into the legal temperature window.
    function automatic temp_t clamp_temp(input delta_t v, input delta_t lo, input delta_t hi);
        delta_t r;
        r = v;
        if (v < lo) r = lo;
        if (v > hi) r = hi;
        return temp_t'(r);
    endfunction

endpackage

// File: rtl/incubator_plant_tick_gen.sv
// Thermal step prescaler: one tick every TICK_DIV cycles, restartable.
module tick_gen #(
    parameter int TICK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(TICK_DIV - 1));
    // A clear (forced load) suppresses the step that would otherwise fire.
    assign tick = wrap & ~clear;

    // Next prescaler value: restart on clear or on wrap.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || wrap) cnt_d = '0;
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/incubator_plant.sv
// Behavioural chamber model: turns heater/cooler commands into temperature.
module incubator_plant
    import incubator_pkg::*;
#(
    parameter int TICK_DIV  = 16,
    parameter int INIT_TEMP = 20,
    parameter int AMBIENT   = 20,
    parameter int HEAT_STEP = 2,
    parameter int WARMUP    = 3,
    parameter int T_MIN     = incubator_pkg::T_MIN,
    parameter int T_MAX     = incubator_pkg::T_MAX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        heater,
    input  logic        cooler,
    input  logic [3:0]  crs,
    input  logic        load_en,
    input  logic [7:0]  load_temp,
    output logic [7:0]  temperature,
    output logic        tick,
    output logic        fault,
    output heat_state_e heat_state
);

    localparam int CNT_W = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;

    // Valid/ready does not apply here: every input is a level sampled only
    // on the step edge (or on the load edge for load_en/load_temp).

    logic             step;
    heat_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
    temp_t            temp_q, temp_d;
    logic             fault_q, fault_d;
    delta_t           delta;
    delta_t           temp_ext;
    delta_t           load_ext;
    logic             unused_crs0;

    assign unused_crs0 = crs[0];

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (reset),
        .clear (load_en),
        .tick  (step)
    );

    assign temp_ext = $signed({{(DELTA_W-TEMP_W){temp_q[TEMP_W-1]}}, temp_q});
    assign load_ext = $signed({{(DELTA_W-TEMP_W){load_temp[TEMP_W-1]}}, load_temp});
    assign cnt_nxt  = (state_q == HS_COLD) ? CNT_W'(1) : cnt_q + CW_ONE();

    function automatic logic [CNT_W-1:0] CW_ONE();
        return CNT_W'(1);
    endfunction

    // Step logic: heater warm-up FSM, temperature delta, clamp and fault.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        temp_d  = temp_q;
        fault_d = fault_q;
        delta   = '0;
        if (load_en) begin
            temp_d = clamp_temp(load_ext, delta_t'(T_MIN), delta_t'(T_MAX));
        end else if (step) begin
            case ({heater, cooler})
                2'b10: begin
                    if (state_q != HS_HOT) begin
                        cnt_d   = cnt_nxt;
                        state_d = (cnt_nxt >= CNT_W'(WARMUP)) ? HS_HOT : HS_WARMING;
                    end
                    // The step that enters HOT already delivers heat.
                    if (state_d == HS_HOT) delta = delta_t'(HEAT_STEP);
                end
                2'b01: begin
                    state_d = HS_COLD;
                    cnt_d   = '0;
                    delta   = -$signed({{(DELTA_W-3){1'b0}}, crs[3:1]});
                end
                2'b00: begin
                    state_d = HS_COLD;
                    cnt_d   = '0;
                    if (temp_q < temp_t'(AMBIENT))      delta = delta_t'(1);
                    else if (temp_q > temp_t'(AMBIENT)) delta = -delta_t'(1);
                end
                default: begin
                    // Both actuators on: latch the fault, hold temperature.
                    state_d = HS_COLD;
                    cnt_d   = '0;
                    fault_d = 1'b1;
                end
            endcase
            temp_d = clamp_temp(temp_ext + delta, delta_t'(T_MIN), delta_t'(T_MAX));
        end
    end

    // State, temperature and fault registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HS_COLD;
            cnt_q   <= '0;
            temp_q  <= temp_t'(INIT_TEMP);
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            temp_q  <= temp_d;
            fault_q <= fault_d;
        end
    end

    assign temperature = temp_q;
    assign fault       = fault_q;
    assign tick        = step;
    assign heat_state  = state_q;

endmodule

// File: tb/tb_incubator_plant.sv
// Self-checking bench for incubator_plant against a step-level thermal model.
module tb_incubator_plant;
    import incubator_pkg::*;

    localparam int TD   = 4;
    localparam int WU   = 2;
    localparam int INIT = 20;
    localparam int AMB  = 20;
    localparam int HSTP = 2;
    localparam int TLO  = -40;
    localparam int THI  = 80;

    logic        clk;
    logic        reset;
    logic        heater;
    logic        cooler;
    logic [3:0]  crs;
    logic        load_en;
    logic [7:0]  load_temp;
    logic [7:0]  temperature;
    logic        tick;
    logic        fault;
    heat_state_e heat_state;

    int n_cmp;
    int n_err;

    // Reference model: temperature, cycles into the current step,
    // consecutive heater-only steps, sticky fault.
    int m_temp;
    int m_phase;
    int m_run;
    int m_fault;

    incubator_plant #(
        .TICK_DIV(TD), .INIT_TEMP(INIT), .AMBIENT(AMB), .HEAT_STEP(HSTP),
        .WARMUP(WU), .T_MIN(TLO), .T_MAX(THI)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .heater      (heater),
        .cooler      (cooler),
        .crs         (crs),
        .load_en     (load_en),
        .load_temp   (load_temp),
        .temperature (temperature),
        .tick        (tick),
        .fault       (fault),
        .heat_state  (heat_state)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "time limit reached");
    end

    function automatic int clampi(input int v);
        if (v < TLO) return TLO;
        if (v > THI) return THI;
        return v;
    endfunction

    function automatic int exp_state();
        if (m_run == 0) return int'(HS_COLD);
        if (m_run < WU) return int'(HS_WARMING);
        return int'(HS_HOT);
    endfunction

    task automatic chk(input string tag, input integer obs, input integer exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_temp  = INIT;
        m_phase = 0;
        m_run   = 0;
        m_fault = 0;
    endtask

    // Apply the specification's rules to one rising edge.
    task automatic model_edge();
        int d;
        int lt;
        if (load_en) begin
            lt      = $signed(load_temp);
            m_temp  = clampi(lt);
            m_phase = 0;
        end else if (m_phase == TD - 1) begin
            m_phase = 0;
            d = 0;
            if (heater && !cooler) begin
                m_run++;
                if (m_run >= WU) d = HSTP;
            end else begin
                m_run = 0;
                if (heater && cooler)  m_fault = 1;
                else if (cooler)       d = -(int'(crs) / 2);
                else if (m_temp < AMB) d = 1;
                else if (m_temp > AMB) d = -1;
            end
            m_temp = clampi(m_temp + d);
        end else begin
            m_phase++;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_temp"}, $signed(temperature), m_temp);
        chk({tag, "_fault"}, fault, m_fault);
        chk({tag, "_state"}, heat_state, exp_state());
    endtask

    // One clock: called at edge+1 with inputs already driven.
    task automatic cycle(input string tag);
        #1;
        chk({tag, "_tick"}, tick, (m_phase == TD - 1 && !load_en) ? 1 : 0);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic steps(input string tag, input int n);
        repeat (n * TD) cycle(tag);
    endtask

    task automatic do_load(input string tag, input int v);
        load_en   = 1'b1;
        load_temp = v[7:0];
        cycle(tag);
        load_en   = 1'b0;
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk({tag, "_rst_temp"}, $signed(temperature), INIT);
        chk({tag, "_rst_tick"}, tick, 0);
        chk({tag, "_rst_fault"}, fault, 0);
        chk({tag, "_rst_state"}, heat_state, int'(HS_COLD));
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        heater = 1'b0;
        cooler = 1'b0;
        crs = CRS_OFF;
        load_en = 1'b0;
        load_temp = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("por");
        reset = 1'b1;

        // 1: reset in the middle of a step; first tick four cycles later.
        repeat (6) cycle("pre");
        do_reset("mid");
        repeat (3) cycle("rel");
        #1;
        chk("first_tick", tick, 1);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs("rel4");

        // 2: drift down towards ambient and hold there.
        do_load("ld30", 30);
        steps("drift", 13);

        // 3: heater warm-up, then drift once it switches off.
        do_load("ld10", 10);
        heater = 1'b1;
        steps("warm", 3);
        heater = 1'b0;
        steps("off", 1);

        // 4: cooler at each legal speed.
        do_load("ld50", 50);
        cooler = 1'b1;
        crs = CRS_HIGH;
        steps("c8", 2);
        crs = CRS_MED;
        steps("c6", 1);
        crs = CRS_LOW;
        steps("c4", 1);
        cooler = 1'b0;

        // 5: saturation at both limits.
        heater = 1'b1;
        steps("heat", 2);
        do_load("ld79", 79);
        steps("top", 3);
        do_load("ld100", 100);
        heater = 1'b0;
        cooler = 1'b1;
        crs = CRS_HIGH;
        do_load("ldm39", -39);
        steps("bot", 3);

        // 6: both actuators on -> sticky fault, cleared only by reset.
        heater = 1'b1;
        steps("both", 1);
        heater = 1'b0;
        cooler = 1'b0;
        steps("after", 2);
        do_reset("clr");
        steps("idle", 1);

        // Randomized traffic, including mid-step pulses and illegal crs codes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) heater = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) cooler = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) crs = 4'($urandom_range(0, 15));
            load_en   = ($urandom_range(0, 19) == 0);
            load_temp = 8'($urandom);
            if (i == 300) do_reset("rnd");
            cycle("rnd");
        end
        load_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
